if_id_reg: RTL
==============

# if_id_reg

Fetch-to-decode pipeline register for the MIPS core: accepts fetched instructions and their PC from the fetch stage through a valid/ready handshake, buffers up to two beats in a skid buffer, and presents the head instruction to decode already split into fields. Its `outImm` output drives the 16-bit input of the sign extender. `outRs` and `outRt` drive the register file read ports. Stalls from decode back-pressure fetch without combinational paths, and a flush discards everything in flight on a branch or jump redirect.

## Interface
- `DEPTH`, 2, buffer entries; fixed at 2, and other values are unsupported.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `inValid`  input  1  fetch presents a beat.
- `inReady`  output  1  block can accept a beat this cycle.
- `inPc`  input  32  PC of the fetched instruction.
- `inInstr`  input  32  fetched instruction word.
- `flush`  input  1  synchronous discard of all buffered and incoming beats.
- `outValid`  output  1  head entry valid to decode.
- `outReady`  input  1  decode consumes the head this cycle.
- `outPc`  output  32  head PC.
- `outInstr`  output  32  head instruction word.
- `outOpcode`  output  6  bits [31:26] of the head word.
- `outRs`  output  5  bits [25:21] of the head word.
- `outRt`  output  5  bits [20:16] of the head word.
- `outRd`  output  5  bits [15:11] of the head word.
- `outShamt`  output  5  bits [10:6] of the head word.
- `outFunct`  output  6  bits [5:0] of the head word.
- `outImm`  output  16  bits [15:0] of the head word; feeds the sign extender.
- `outTarget`  output  26  bits [25:0] of the head word.

## Operation
- **Storage.** Two entries `{pc, instr}` with read pointer `rdPtr` (1 bit), write pointer `wrPtr` (1 bit) and `count` (0..2).
- **Push.** `push = inValid & inReady & ~flush`. It writes entry `wrPtr`, then toggles `wrPtr`.
- **Pop.** `pop = outValid & outReady & ~flush`. It toggles `rdPtr`.
- **Count update.**
  - `push & ~pop`: count + 1.
  - `pop & ~push`: count − 1.
  - Push and pop together: count unchanged. This is legal only at count = 1.
- **Handshake outputs.**
  - `inReady = (count != 2)`, a function of state only.
  - `outValid = (count != 0)`.
- **Flush.**
  - On the next edge: count ← 0, `rdPtr` ← 0, `wrPtr` ← 0.
  - The beat offered in the flush cycle is dropped, even if `inValid & inReady`.
  - A decode pop in the flush cycle does not count as consumed by this block. Decode must itself ignore that cycle.
  - Flush has priority over push and pop.
- **Field outputs.**
  - All field outputs are pure slices of `outInstr`.
  - `outPc` and `outInstr` come from entry `rdPtr` when count != 0.
  - They are forced to 0 when count = 0. This makes an empty slot decode as `sll $0,$0,0` (NOP) and gives `outImm` = 0x0000.
- **Stability.** While `outValid & ~outReady` and no flush, the head outputs hold stable.
- **Ordering.** Order is strictly FIFO; no beat is duplicated or lost except by flush.
- **Pointer wrap.** Pointers are 1 bit and wrap 1→0 naturally.
- **Asynchronous reset.** `rst_n` low immediately clears count, both pointers and both entries to 0. Resulting outputs: `inReady` = 1, `outValid` = 0, all data outputs 0.
  - Reset asserted mid-transfer abandons the beat.
  - Reset release is synchronous to `clk` (handled upstream).

## Timing
- **Latency.** A beat accepted at edge N is visible with `outValid` = 1 in the cycle after edge N. There is no combinational path from `in*` to `out*`.
- **No combinational ready paths.** `inReady` does not depend on `outReady`; it depends on registered count only.
- **Throughput.**
  - One beat per cycle with `outReady` held 1.
  - When `outReady` drops, a second beat is absorbed. `inReady` then falls in the following cycle.
- **Recovery after flush.** `inReady` = 1 in the cycle after a flush edge, and a new beat can be accepted immediately.

## Test plan
- **Reset.** Assert `rst_n` = 0 mid-cycle with count = 2 → outputs clear at once: `outValid` = 0, `inReady` = 1, `outInstr` = 0x00000000, `outImm` = 0x0000.
- **Streaming.** Stream 0x2408FFFF @PC 0x00400000, then 0x8D090004 @PC 0x00400004, with `outReady` = 1 → each appears one cycle after acceptance. The first shows `outOpcode` = 0x09, `outRt` = 8, `outImm` = 0xFFFF. The second shows `outImm` = 0x0004.
- **Back-pressure.** Hold `outReady` = 0 while pushing 3 beats → first two accepted, `inReady` = 0 after the second. The third is held by fetch. Head stays at the first beat. Releasing `outReady` drains in order with no gaps.
- **Simultaneous push/pop at count = 1.** Drive push and pop in the same cycle → count stays 1 and `outInstr` advances to the new beat.
- **Flush.** Assert `flush` with count = 2 and `inValid` = 1 → next cycle `outValid` = 0. The offered beat is dropped, `inReady` = 1, and the next pushed beat appears as the head.
- **Pointer wrap.** Push and pop 5 beats with alternating `outReady` → FIFO order is preserved across the `rdPtr`/`wrPtr` 1→0 wrap.

Source files
------------

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_reg
//  Purpose  : Fetch-to-decode pipeline register. A two-entry skid buffer sits
//             between fetch and decode behind valid/ready handshakes. The head
//             instruction is presented already split into MIPS fields. A flush
//             discards every buffered beat and the beat offered that cycle.
//  Ports    : clk, rst_n (async, active-low)
//             inValid/inReady/inPc/inInstr     - fetch side
//             flush                            - branch/jump redirect
//             outValid/outReady/outPc/outInstr - decode side
//             outOpcode/outRs/outRt/outRd/outShamt/outFunct/outImm/outTarget
//                                              - slices of outInstr
//  Revision : 1.0 - initial release
// ============================================================================
module if_id_reg #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] inPc,
    input  logic [31:0] inInstr,
    input  logic        flush,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] outPc,
    output logic [31:0] outInstr,
    output logic [5:0]  outOpcode,
    output logic [4:0]  outRs,
    output logic [4:0]  outRt,
    output logic [4:0]  outRd,
    output logic [4:0]  outShamt,
    output logic [5:0]  outFunct,
    output logic [15:0] outImm,
    output logic [25:0] outTarget
);

    localparam logic [1:0] c_FULL  = 2'(DEPTH);
    localparam logic [1:0] c_EMPTY = 2'd0;

    logic [31:0] r_pc    [0:1];
    logic [31:0] r_instr [0:1];
    logic        r_rdPtr;
    logic        r_wrPtr;
    logic [1:0]  r_count;

    logic        w_push;
    logic        w_pop;

    // Handshakes depend on registered occupancy only, so no combinational
    // path exists between the two sides.
    assign inReady  = (r_count != c_FULL);
    assign outValid = (r_count != c_EMPTY);

    // Flush overrides both transfers in the same cycle.
    assign w_push = inValid & inReady & ~flush;
    assign w_pop  = outValid & outReady & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_rdPtr <= 1'b0;
            r_wrPtr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_pc[i]    <= 32'd0;
                r_instr[i] <= 32'd0;
            end
        end else if (flush) begin
            // Stale entry contents are harmless: outputs are masked while empty.
            r_count <= 2'd0;
            r_rdPtr <= 1'b0;
            r_wrPtr <= 1'b0;
        end else begin
            if (w_push) begin
                r_pc[r_wrPtr]    <= inPc;
                r_instr[r_wrPtr] <= inInstr;
                r_wrPtr          <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // An empty slot reads as all-zero, which decodes as sll $0,$0,0 (NOP).
    assign outPc    = outValid ? r_pc[r_rdPtr]    : 32'd0;
    assign outInstr = outValid ? r_instr[r_rdPtr] : 32'd0;

    assign outOpcode = outInstr[31:26];
    assign outRs     = outInstr[25:21];
    assign outRt     = outInstr[20:16];
    assign outRd     = outInstr[15:11];
    assign outShamt  = outInstr[10:6];
    assign outFunct  = outInstr[5:0];
    assign outImm    = outInstr[15:0];
    assign outTarget = outInstr[25:0];

endmodule
`default_nettype wire
